// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-stage pipeline register with valid, stall, flush and occupancy count
// Ports: clk, rst (sync, active-high), stall_in (hold all stages), flush_in (bubble all stages),
//   valid_in/ctrl_in/data_in (incoming slot), valid_out/ctrl_out/data_out (last stage),
//   occupancy (valid stage count). With PIPE_STAGE_STALL_CNT_EN defined, stall_cycles
//   counts stalled cycles while occupied, saturating at 16'hFFFF.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be 1..4");
  end
  logic [DEPTH-1:0] v, v_nxt;
  logic [CTRL_W-1:0] c [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];
  // Index s holds what stage s loads on an advance: entry 0 is the input slot.
  logic [DEPTH:0] vi;
  logic [CTRL_W-1:0] ci [DEPTH+1];
  logic [DATA_W-1:0] di [DEPTH+1];
  logic [2:0] occ_nxt;
  always_comb begin
    vi = {v, valid_in};
    ci[0] = valid_in ? ctrl_in : '0;
    di[0] = data_in;
    for (int s = 0; s < DEPTH; s++) begin
      ci[s+1] = c[s];
      di[s+1] = d[s];
    end
    v_nxt = flush_in ? '0 : stall_in ? v : vi[DEPTH-1:0];
    occ_nxt = '0;
    for (int s = 0; s < DEPTH; s++) occ_nxt = occ_nxt + {2'b00, v_nxt[s]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      occupancy <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        c[s] <= '0;
        d[s] <= '0;
      end
    end else begin
      v <= v_nxt;
      occupancy <= occ_nxt;
      for (int s = 0; s < DEPTH; s++) begin
        if (flush_in) c[s] <= '0;
        else if (!stall_in) begin
          c[s] <= ci[s];
          d[s] <= di[s];
        end
      end
    end
  end
`ifdef PIPE_STAGE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (stall_in && !flush_in && occupancy != 3'd0 && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif
  assign valid_out = v[DEPTH-1];
  assign ctrl_out  = c[DEPTH-1];
  assign data_out  = d[DEPTH-1];
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector, directed and random checks of pipe_stage_reg at DEPTH 1, 2 and 3
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, stall_in, flush_in, valid_in;
  logic [3:0] ctrl_in;
  logic [15:0] data_in;
  logic v1, v2, v3;
  logic [3:0] c1, c2, c3;
  logic [15:0] d1, d2, d3;
  logic [2:0] o1, o2, o3;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] s1, s2, s3;
`endif
  int checks = 0, errors = 0;

  pipe_stage_reg #(.DEPTH(1)) u1 (.clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(v1), .ctrl_out(c1),
    .data_out(d1), .occupancy(o1)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cycles(s1)
`endif
  );
  pipe_stage_reg #(.DEPTH(2)) u2 (.clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(v2), .ctrl_out(c2),
    .data_out(d2), .occupancy(o2)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cycles(s2)
`endif
  );
  pipe_stage_reg #(.DEPTH(3)) u3 (.clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .valid_out(v3), .ctrl_out(c3),
    .data_out(d3), .occupancy(o3)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cycles(s3)
`endif
  );

  typedef struct {
    logic r, s, f, v;
    logic [3:0] c;
    logic [15:0] d;
    logic ev;
    logic [3:0] ec;
    logic [15:0] ed;
    logic [2:0] eo;
  } vec_t;
  typedef struct {
    logic v;
    logic [3:0] c;
    logic [15:0] d;
  } slot_t;

  vec_t tbl [12];
  slot_t m [3][4];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [3:0] c, input logic [15:0] d);
    rst = r; stall_in = s; flush_in = f; valid_in = v; ctrl_in = c; data_in = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 4'h0, 16'h0);
    // reset held with a live-looking slot on the input: nothing may leak through
    drive(1, 0, 0, 1, 4'hF, 16'hABCD);
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("rst_valid", v3, 0); chk("rst_ctrl", c3, 0); chk("rst_data", d3, 0); chk("rst_occ", o3, 0);
    end
    drive(0, 0, 0, 0, 4'hF, 16'hABCD);
    tick;
    chk("rel_valid", v3, 0); chk("rel_ctrl", c3, 0); chk("rel_data", d3, 0); chk("rel_occ", o3, 0);

    // latency/streaming on DEPTH=3: data 1..4 then bubbles
    begin
      logic [2:0] occ_exp [6];
      occ_exp = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1};
      for (int k = 0; k < 6; k++) begin
        drive(0, 0, 0, k < 4, 4'h5, 16'(k + 1));
        tick;
        chk("lat_occ", o3, occ_exp[k]);
        if (k < 2) chk("lat_early_valid", v3, 0);
        else begin
          chk("lat_valid", v3, 1); chk("lat_ctrl", c3, 4'h5); chk("lat_data", d3, 16'(k - 1));
        end
      end
    end

    // bubble on DEPTH=1: ctrl dropped, data captured
    drive(0, 0, 0, 0, 4'hF, 16'h1234);
    tick;
    chk("bub_valid", v1, 0); chk("bub_ctrl", c1, 0); chk("bub_data", d1, 16'h1234);

    // stall then flush-during-stall on DEPTH=2
    tbl[0]  = '{1, 0, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 3'd0};
    tbl[1]  = '{0, 0, 0, 1, 4'h3, 16'h0011, 0, 4'h0, 16'h0000, 3'd1};
    tbl[2]  = '{0, 0, 0, 1, 4'h3, 16'h0022, 1, 4'h3, 16'h0011, 3'd2};
    tbl[3]  = '{0, 1, 0, 1, 4'h3, 16'h0033, 1, 4'h3, 16'h0011, 3'd2};
    tbl[4]  = '{0, 1, 0, 1, 4'h3, 16'h0033, 1, 4'h3, 16'h0011, 3'd2};
    tbl[5]  = '{0, 1, 0, 1, 4'h3, 16'h0033, 1, 4'h3, 16'h0011, 3'd2};
    tbl[6]  = '{0, 0, 0, 1, 4'h3, 16'h0033, 1, 4'h3, 16'h0022, 3'd2};
    tbl[7]  = '{0, 0, 0, 0, 4'h3, 16'h0000, 1, 4'h3, 16'h0033, 3'd1};
    tbl[8]  = '{0, 0, 0, 1, 4'h3, 16'h0044, 0, 4'h0, 16'h0000, 3'd1};
    tbl[9]  = '{0, 0, 0, 1, 4'h3, 16'h0055, 1, 4'h3, 16'h0044, 3'd2};
    tbl[10] = '{0, 1, 1, 1, 4'h3, 16'h0066, 0, 4'h0, 16'h0044, 3'd0};
    tbl[11] = '{0, 0, 0, 0, 4'hF, 16'h0077, 0, 4'h0, 16'h0055, 3'd0};
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].r, tbl[k].s, tbl[k].f, tbl[k].v, tbl[k].c, tbl[k].d);
      tick;
      chk($sformatf("vec%0d_valid", k), v2, tbl[k].ev);
      chk($sformatf("vec%0d_ctrl", k), c2, tbl[k].ec);
      chk($sformatf("vec%0d_data", k), d2, tbl[k].ed);
      chk($sformatf("vec%0d_occ", k), o2, tbl[k].eo);
    end

    // random stimulus against a slot-list model for each depth
    for (int i = 0; i < 2000; i++) begin
      logic r, s, f, v;
      logic [3:0] c;
      logic [15:0] d;
      r = (i == 0) || ($urandom_range(39) == 0);
      s = $urandom_range(3) == 0;
      f = $urandom_range(15) == 0;
      v = $urandom_range(1) == 1;
      c = 4'($urandom);
      d = 16'($urandom);
      drive(r, s, f, v, c, d);
      tick;
      for (int x = 0; x < 3; x++) begin
        int n, cnt;
        logic ov;
        logic [3:0] oc;
        logic [15:0] od;
        logic [2:0] oo;
        n = x + 1;
        if (r) for (int y = 0; y < 4; y++) m[x][y] = '{1'b0, 4'h0, 16'h0};
        else if (f) for (int y = 0; y < 4; y++) begin m[x][y].v = 1'b0; m[x][y].c = 4'h0; end
        else if (!s) begin
          for (int y = n - 1; y > 0; y--) m[x][y] = m[x][y-1];
          m[x][0] = '{v, v ? c : 4'h0, d};
        end
        cnt = 0;
        for (int y = 0; y < n; y++) cnt += int'(m[x][y].v);
        ov = x == 0 ? v1 : x == 1 ? v2 : v3;
        oc = x == 0 ? c1 : x == 1 ? c2 : c3;
        od = x == 0 ? d1 : x == 1 ? d2 : d3;
        oo = x == 0 ? o1 : x == 1 ? o2 : o3;
        chk($sformatf("rnd%0d_d%0d_valid", i, n), ov, m[x][n-1].v);
        chk($sformatf("rnd%0d_d%0d_ctrl", i, n), oc, m[x][n-1].c);
        chk($sformatf("rnd%0d_d%0d_data", i, n), od, m[x][n-1].d);
        chk($sformatf("rnd%0d_d%0d_occ", i, n), oo, 3'(cnt));
      end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    drive(1, 0, 0, 0, 4'h0, 16'h0); tick;
    drive(0, 0, 0, 1, 4'h1, 16'h0001); tick;
    drive(0, 1, 0, 0, 4'h0, 16'h0000);
    repeat (5) tick;
    chk("sc_five", s1, 16'd5);
    drive(0, 0, 1, 0, 4'h0, 16'h0000); tick;
    drive(0, 1, 0, 0, 4'h0, 16'h0000);
    repeat (2) tick;
    chk("sc_empty_stall", s1, 16'd5);
    drive(0, 0, 1, 0, 4'h0, 16'h0000); tick;
    chk("sc_flush", s1, 16'd5);
    drive(1, 0, 0, 0, 4'h0, 16'h0000); tick;
    chk("sc_rst", s1, 16'd0);
    drive(0, 0, 0, 1, 4'h1, 16'h0001); tick;
    drive(0, 1, 0, 0, 4'h0, 16'h0000);
    repeat (70000) @(posedge clk);
    #1;
    chk("sc_sat", s1, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
